// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_WAIT   = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int LOAD_USE_STALLS_DEFAULT = 1;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller bundle: hazard sources in, stall/bubble controls out.
// There is no handshake here: every control output is a same-cycle combinational response to the sources.
interface hazard_controller_if import hazard_pkg::*; #(parameter int CNT_W = 32);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_mdu_valid;
  logic             mdu_done;
  logic             mem_req_MEM;
  logic             mem_ready_MEM;
  logic             branch_taken_EX;

  logic             stall_IF;
  logic             stall_ID;
  logic             stall_EX;
  logic             stall_MEM;
  logic             flush_ID;
  logic             bubble_EX;
  logic             bubble_MEM;
  logic             bubble_WB;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  hz_state_t        dbg_state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_mdu_valid, mdu_done, mem_req_MEM, mem_ready_MEM, branch_taken_EX,
    input  stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, bubble_EX,
           bubble_MEM, bubble_WB, stall_cycles, flush_count, dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_mdu_valid, mdu_done, mem_req_MEM, mem_ready_MEM, branch_taken_EX,
    output stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, bubble_EX,
           bubble_MEM, bubble_WB, stall_cycles, flush_count, dbg_state
  );

endinterface

// File: rtl/hazard_perf_counters.sv
// Two free-running wrapping event counters (stalled cycles, branch flushes).
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stall_en,
  input  logic             i_flush_en,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (i_stall_en) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (i_flush_en) r_flush_count  <= r_flush_count + CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. Perf counters are built only
// when HAZARD_PERF_EN is defined; otherwise the counter outputs read 0.
module hazard_controller import hazard_pkg::*; #(
  parameter int LOAD_USE_STALLS = LOAD_USE_STALLS_DEFAULT,
  parameter int CNT_W           = 32
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  bus
);

  localparam logic [2:0] LUS_RELOAD = 3'(LOAD_USE_STALLS - 1);

  hz_state_t  r_state, w_next_state;
  logic [2:0] r_cnt, w_next_cnt;
  logic       r_done_pending, w_next_pending;

  logic w_memwait, w_loaduse;
  logic w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
  logic w_flush_id, w_bubble_ex, w_bubble_mem, w_bubble_wb;

  assign w_memwait = bus.mem_req_MEM & ~bus.mem_ready_MEM;
  assign w_loaduse = bus.ex_is_load & (bus.ex_rd != REG_X0) &
                     ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                      (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= RUN;
      r_cnt          <= 3'd0;
      r_done_pending <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_next_cnt;
      r_done_pending <= w_next_pending;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_next_pending = r_done_pending;
    w_stall_if     = 1'b0;
    w_stall_id     = 1'b0;
    w_stall_ex     = 1'b0;
    w_stall_mem    = 1'b0;
    w_flush_id     = 1'b0;
    w_bubble_ex    = 1'b0;
    w_bubble_mem   = 1'b0;
    w_bubble_wb    = 1'b0;
    if (reset) begin
      w_next_state = RUN;
    end else if (w_memwait) begin
      // Whole front of the pipe freezes; a done pulse seen now must not be lost.
      {w_stall_if, w_stall_id, w_stall_ex, w_stall_mem, w_bubble_wb} = 5'b11111;
      if (bus.mdu_done) w_next_pending = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.branch_taken_EX) begin
            w_flush_id  = 1'b1;
            w_bubble_ex = 1'b1;
          end else if (bus.ex_mdu_valid & ~bus.mdu_done) begin
            {w_stall_if, w_stall_id, w_stall_ex, w_bubble_mem} = 4'b1111;
            w_next_state = MDU_WAIT;
          end else if (w_loaduse) begin
            {w_stall_if, w_stall_id, w_bubble_ex} = 3'b111;
            if (LOAD_USE_STALLS > 1) begin
              w_next_state = LOAD_STALL;
              w_next_cnt   = LUS_RELOAD;
            end
          end
        end
        LOAD_STALL: begin
          {w_stall_if, w_stall_id, w_bubble_ex} = 3'b111;
          w_next_cnt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_next_state = RUN;
        end
        MDU_WAIT: begin
          if (bus.mdu_done | r_done_pending) begin
            w_next_pending = 1'b0;
            w_next_state   = RUN;
          end else begin
            {w_stall_if, w_stall_id, w_stall_ex, w_bubble_mem} = 4'b1111;
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  assign bus.stall_IF   = w_stall_if;
  assign bus.stall_ID   = w_stall_id;
  assign bus.stall_EX   = w_stall_ex;
  assign bus.stall_MEM  = w_stall_mem;
  assign bus.flush_ID   = w_flush_id;
  assign bus.bubble_EX  = w_bubble_ex;
  assign bus.bubble_MEM = w_bubble_mem;
  assign bus.bubble_WB  = w_bubble_wb;
  assign bus.dbg_state  = r_state;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] w_stall_cycles;
  logic [CNT_W-1:0] w_flush_count;

  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_stall_en     (w_stall_if),
    .i_flush_en     (w_flush_id),
    .o_stall_cycles (w_stall_cycles),
    .o_flush_count  (w_flush_count)
  );

  assign bus.stall_cycles = reset ? '0 : w_stall_cycles;
  assign bus.flush_count  = reset ? '0 : w_flush_count;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed hazard scenarios then random traffic.
module tb_hazard_controller;

  localparam int LUS   = 3;
  localparam int CNT_W = 32;
  localparam int W     = 8 + 2 * CNT_W;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(CNT_W)) bus();

  hazard_controller #(.LOAD_USE_STALLS(LUS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: remaining load bubbles, MDU wait flag, latched done, event totals.
  int               load_left   = 0;
  bit               mdu_waiting = 1'b0;
  bit               done_pend   = 1'b0;
  logic [CNT_W-1:0] m_stalls    = '0;
  logic [CNT_W-1:0] m_flushes   = '0;

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                      input logic mv, input logic md, input logic mq, input logic mr,
                      input logic br);
    logic [7:0] c;  // {sIF,sID,sEX,sMEM,fID,bEX,bMEM,bWB}
    logic lu;
    @(posedge clk);
    #1;
    reset = rst;
    bus.id_rs1 = rs1;       bus.id_rs2 = rs2;
    bus.id_uses_rs1 = u1;   bus.id_uses_rs2 = u2;
    bus.ex_rd = rd;         bus.ex_is_load = ld;
    bus.ex_mdu_valid = mv;  bus.mdu_done = md;
    bus.mem_req_MEM = mq;   bus.mem_ready_MEM = mr;
    bus.branch_taken_EX = br;
    c  = 8'b0;
    lu = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst) begin
      load_left = 0; mdu_waiting = 1'b0; done_pend = 1'b0;
      m_stalls = '0; m_flushes = '0;
    end else if (mq && !mr) begin
      c = 8'b1111_0001;
      if (md) done_pend = 1'b1;
    end else if (mdu_waiting) begin
      if (md || done_pend) begin
        mdu_waiting = 1'b0; done_pend = 1'b0;
      end else c = 8'b1110_0010;
    end else if (load_left > 0) begin
      c = 8'b1100_0100;
      load_left = load_left - 1;
    end else if (br) begin
      c = 8'b0000_1100;
    end else if (mv && !md) begin
      c = 8'b1110_0010;
      mdu_waiting = 1'b1;
    end else if (lu) begin
      c = 8'b1100_0100;
      load_left = LUS - 1;
    end
    exp_q.push_back({c, PERF ? m_stalls : {CNT_W{1'b0}}, PERF ? m_flushes : {CNT_W{1'b0}}});
    if (!rst) begin
      if (c[7]) m_stalls = m_stalls + 1;
      if (c[3]) m_flushes = m_flushes + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one response per cycle, compared mid-cycle on the falling edge.
  initial begin
    logic [W-1:0] exp_v, act_v;
    int cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.stall_MEM,
                 bus.flush_ID, bus.bubble_EX, bus.bubble_MEM, bus.bubble_WB,
                 bus.stall_cycles, bus.flush_count};
        total++;
        if (act_v[W-1 -: 8] !== exp_v[W-1 -: 8]) begin
          bad++;
          $display("FAIL controls cyc=%0d got=%b want=%b", cyc, act_v[W-1 -: 8], exp_v[W-1 -: 8]);
        end
        total++;
        if (act_v[2*CNT_W-1:0] !== exp_v[2*CNT_W-1:0]) begin
          bad++;
          $display("FAIL counters cyc=%0d got=%h want=%h", cyc, act_v[2*CNT_W-1:0], exp_v[2*CNT_W-1:0]);
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs1, then load to x0, then unused source register
    step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0);
    idle(4);
    step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    step(0, 0, 7, 0, 1, 7, 1, 0, 0, 0, 0, 0);
    idle(3);
    // MDU done four cycles after the op appears
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    idle(2);
    // memwait inside MDU_WAIT with done arriving under it
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    idle(2);
    // branch beats load-use; branch under memwait flushes only once released
    step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    // reset arriving while the load stall still has two bubbles to go
    step(0, 3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) < 2),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
           5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) < 1), ($urandom_range(0, 19) < 3),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 9) < 1));
    idle(2);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It takes hazard sources from ID, EX and MEM: load-use dependences, multi-cycle MDU ops in EX, data-memory wait states and taken branches/jumps resolved in EX. It drives per-stage hold and bubble controls for the pipeline registers. Operand forwarding is handled elsewhere; this block resolves only what forwarding cannot.

Parameters:
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_mdu_valid  in  1  multi-cycle MDU op occupies EX
mdu_done  in  1  MDU result ready (1-cycle pulse)
mem_req_MEM  in  1  MEM stage issues data-memory access
mem_ready_MEM  in  1  data memory completes access this cycle
branch_taken_EX  in  1  taken branch/jump resolved in EX
stall_IF  out  1  hold PC
stall_ID  out  1  hold IF/ID register
stall_EX  out  1  hold ID/EX register
stall_MEM  out  1  hold EX/MEM register
flush_ID  out  1  zero IF/ID register
bubble_EX  out  1  zero ID/EX register (NOP)
bubble_MEM  out  1  zero EX/MEM register
bubble_WB  out  1  zero MEM/WB register
stall_cycles  out  CNT_W  perf: cycles with stall_IF=1
flush_count  out  CNT_W  perf: taken-branch flushes

Behaviour:
- State enum: RUN, LOAD_STALL, MDU_WAIT. Register cnt[2:0] and flag done_pending.
- Outputs are combinational from state, cnt and inputs, so they act in the same cycle. While reset=1, all outputs are 0. Reset returns to RUN, cnt=0, done_pending=0, counters=0, also when asserted mid-stall.
- memwait = mem_req_MEM & ~mem_ready_MEM. It has highest priority in any state: stall_IF/ID/EX/MEM=1, bubble_WB=1, all other outputs 0. State and cnt freeze. An mdu_done seen during memwait sets done_pending.
- RUN:
  - Taken branch: branch_taken_EX gives flush_ID=1 and bubble_EX=1. It overrides a load-use match in the same cycle; no stall occurs.
  - MDU wait: ex_mdu_valid & ~mdu_done gives stall_IF/ID/EX=1 and bubble_MEM=1, then goes to MDU_WAIT. If mdu_done arrives with ex_mdu_valid, there is no stall.
  - Load-use: loaduse = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). It gives stall_IF/ID=1 and bubble_EX=1. If LOAD_USE_STALLS>1, go to LOAD_STALL with cnt=LOAD_USE_STALLS-1.
  - Priority: memwait > branch > MDU > load-use.
- LOAD_STALL: stall_IF/ID=1 and bubble_EX=1 each cycle, with cnt decrementing. When cnt==1 in a non-memwait cycle, this is the last bubble and the next state is RUN. Total bubbles equal exactly LOAD_USE_STALLS.
- MDU_WAIT: stall_IF/ID/EX=1 and bubble_MEM=1 until (mdu_done | done_pending) in a non-memwait cycle. In that release cycle stalls are 0, done_pending is cleared and the next state is RUN.
- branch_taken_EX is acted on only when stall_EX=0. While EX is held the branch is simply re-presented.
- Perf counters wrap modulo 2^CNT_W.

Optional Feature:
HAZARD_PERF_EN. When defined, stall_cycles increments on every cycle with stall_IF=1, and flush_count increments on every cycle with flush_ID=1. When undefined, both ports remain and are tied to 0, and no counter flops are built.

Decomposition:
- Package hazard_pkg holds the state enum hz_state_t, the REG_X0 constant (5'd0) and the default LOAD_USE_STALLS.
- One natural sub-module, hazard_perf_counters: the two wrapping counters with their enables, instantiated only under HAZARD_PERF_EN.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of stall_IF=stall_ID=bubble_EX=1, then 0. With LOAD_USE_STALLS=3 → exactly 3 cycles.
- Load to x0 (ex_rd=0, id_rs1=0) → no stall. Same regs with id_uses_rs1=0 → no stall.
- MDU: ex_mdu_valid=1, mdu_done arrives 4 cycles later → stall_IF/ID/EX and bubble_MEM high for 4 cycles, release on the done cycle, back to RUN.
- memwait inside MDU_WAIT, mdu_done pulsed during it, mem_ready 3 cycles later → stall_MEM/bubble_WB for 3 cycles; done_pending releases MDU_WAIT on the next cycle with no lost done.
- branch_taken_EX together with a load-use match → flush_ID=bubble_EX=1, no stall. branch_taken_EX during memwait → no flush until mem_ready, then one flush; flush_count=1 under HAZARD_PERF_EN.
- Reset asserted mid LOAD_STALL (cnt=2) → all outputs 0 during reset, RUN afterwards, counters 0.
